// File: rtl/fft_mag_writer.sv
// fft_mag_writer: writes one frame-aligned FFT magnitude spectrum per arm request into the spectrum RAM.
// Define FFT_MAG_APPROX_EN for the alpha-max-beta-min magnitude instead of exact re^2 + im^2.
module fft_mag_writer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  input  logic                arm,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                wr_en
);
  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DRAIN} state_t;
`ifdef FFT_MAG_APPROX_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = 2 * DATA_W;
`endif
  state_t state, state_n;
  logic [ADDR_W-1:0] count, count_n, a0, a1;
  logic [1:0] dc, dc_n;
  logic err_n, take, v0, v1;
  logic signed [DATA_W-1:0] re0, im0;
  logic [PW-1:0] f_re, f_im, p_re, p_im;
  logic [2*DATA_W-1:0] mag;
`ifdef FFT_MAG_APPROX_EN
  logic [PW-1:0] mx, mn;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    count_n = count;
    dc_n = '0;
    err_n = frame_err;
    take = 1'b0;
    case (state)
      IDLE: if (arm) begin
        state_n = SYNC;
        err_n = 1'b0;
      end
      SYNC: begin
        count_n = '0;
        if (s_tvalid && s_tlast) state_n = CAPTURE;
      end
      CAPTURE: if (s_tvalid) begin
        take = 1'b1;
        count_n = s_tlast ? '0 : count + 1'b1;
        // every count wrap is a framing decision: exact fit drains, otherwise flag and resync
        if (s_tlast && &count) state_n = DRAIN;
        else if (s_tlast || &count) err_n = 1'b1;
        if (!s_tlast && &count) state_n = SYNC;
      end
      DRAIN: begin
        dc_n = dc + 1'b1;
        if (dc == 2'd2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      dc <= '0;
      frame_err <= 1'b0;
      frame_done <= 1'b0;
      s_tready <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      dc <= dc_n;
      frame_err <= err_n;
      frame_done <= state == DRAIN && dc == 2'd2;
      s_tready <= 1'b1;
    end
  end
  always_comb begin
`ifdef FFT_MAG_APPROX_EN
    f_re = re0[DATA_W-1] ? -PW'(re0) : PW'(re0);
    f_im = im0[DATA_W-1] ? -PW'(im0) : PW'(im0);
    mx = p_re > p_im ? p_re : p_im;
    mn = p_re > p_im ? p_im : p_re;
    mag = (2*DATA_W)'(mx + (mn >> 1));
`else
    f_re = PW'(re0) * PW'(re0);
    f_im = PW'(im0) * PW'(im0);
    mag = p_re + p_im;
`endif
  end
  // input register, stage 1 (squares/abs), stage 2 (sum) driving the RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      wr_en <= 1'b0;
      a0 <= '0;
      a1 <= '0;
      wr_addr <= '0;
      re0 <= '0;
      im0 <= '0;
      p_re <= '0;
      p_im <= '0;
      wr_data <= '0;
    end else begin
      v0 <= take;
      a0 <= count;
      re0 <= s_tdata[DATA_W-1:0];
      im0 <= s_tdata[2*DATA_W-1:DATA_W];
      v1 <= v0;
      a1 <= a0;
      p_re <= f_re;
      p_im <= f_im;
      wr_en <= v1;
      wr_addr <= a1;
      wr_data <= v1 ? mag : wr_data;
    end
  end
endmodule
